// File: rtl/q_edge_logger.sv
// q_edge_logger
//
// Logs every accepted transition of the upstream stage output q as a
// timestamped event in a small first-word-fall-through FIFO. A consumer
// drains the FIFO over a valid/ready handshake. Events that find the FIFO
// full (with no pop in the same cycle) are dropped and counted.
//
// Build option: define Q_EDGE_LOGGER_GLITCH_FILTER_EN to compile in the glitch
// filter. With the filter, q must differ from the accepted level for
// FILTER_LEN consecutive samples before an event is logged. Without it,
// every sampled transition is logged one cycle after it is sampled.
//
// Parameters:
//   TS_W       timestamp counter width
//   DEPTH      FIFO entries (power of two, >= 2)
//   FILTER_LEN stability length in samples (filter build only, >= 2)
//
// Ports:
//   clk, rst   clock; asynchronous active-high reset
//   a, b, c    operands driven into the upstream stage
//   q          upstream stage output
//   ev_valid   FIFO head holds an event
//   ev_ready   consumer accepts the head event
//   ev_rise    1 = rising edge of q, 0 = falling edge
//   ev_abc     {a,b,c} sampled together with the q value that caused the event
//   ev_ts      timestamp of the event (ts of the cycle the edge was sampled in)
//   drop_cnt   dropped-event count, saturates at 255
//   ovf        sticky, set on the first drop
module q_edge_logger #(
    parameter int TS_W       = 16,
    parameter int DEPTH      = 4,
    parameter int FILTER_LEN = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            a,
    input  logic            b,
    input  logic            c,
    input  logic            q,
    output logic            ev_valid,
    input  logic            ev_ready,
    output logic            ev_rise,
    output logic [2:0]      ev_abc,
    output logic [TS_W-1:0] ev_ts,
    output logic [7:0]      drop_cnt,
    output logic            ovf
);

    localparam int AW = $clog2(DEPTH);

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("q_edge_logger: DEPTH must be a power of two and at least 2");
        end
        if (FILTER_LEN < 2) begin : g_bad_filter
            $error("q_edge_logger: FILTER_LEN must be at least 2");
        end
    endgenerate

    // ---- sampling stage: q, operands and timestamp captured together ----
    logic            q_s;
    logic [2:0]      abc_s;
    logic [TS_W-1:0] ts;
    logic [TS_W-1:0] ts_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_s <= 1'b0;
            ts  <= '0;
        end else begin
            q_s <= q;
            ts  <= ts + 1'b1;
        end
    end

    // Data-only registers: they are always written the cycle before any
    // event can consume them, so they need no reset.
    always_ff @(posedge clk) begin
        abc_s <= {a, b, c};
        ts_s  <= ts;
    end

    // ---- level acceptance stage: q_f and event generation ----
    logic q_f;
    logic wr_en;

`ifdef Q_EDGE_LOGGER_GLITCH_FILTER_EN
    localparam int CW = $clog2(FILTER_LEN);

    // Counts edges at which q_s has disagreed with q_f; the edge that would
    // make the count reach FILTER_LEN is the one that accepts the new level.
    logic [CW-1:0] flt_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_f     <= 1'b0;
            flt_cnt <= '0;
        end else if (q_s == q_f) begin
            flt_cnt <= '0;
        end else if (flt_cnt == CW'(FILTER_LEN - 1)) begin
            q_f     <= q_s;
            flt_cnt <= '0;
        end else begin
            flt_cnt <= flt_cnt + 1'b1;
        end
    end

    assign wr_en = (q_s != q_f) && (flt_cnt == CW'(FILTER_LEN - 1));
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_f <= 1'b0;
        end else begin
            q_f <= q_s;
        end
    end

    assign wr_en = (q_s != q_f);
`endif

    // ---- event FIFO stage ----
    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]     wr_ptr;
    logic [AW:0]     rd_ptr;
    logic            rise_mem [DEPTH];
    logic [2:0]      abc_mem  [DEPTH];
    logic [TS_W-1:0] ts_mem   [DEPTH];
    logic            empty;
    logic            full;
    logic            pop;
    logic            push;
    logic            drop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = ((wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}});
    assign pop   = ev_valid && ev_ready;
    // A pop in the same cycle frees the slot the write needs.
    assign push  = wr_en && (!full || pop);
    assign drop  = wr_en && full && !pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            rise_mem[wr_ptr[AW-1:0]] <= q_s;
            abc_mem[wr_ptr[AW-1:0]]  <= abc_s;
            ts_mem[wr_ptr[AW-1:0]]   <= ts_s;
        end
    end

    // Head fields are forced to 0 while empty so they read as 0 out of reset.
    assign ev_valid = !empty;
    assign ev_rise  = ev_valid & rise_mem[rd_ptr[AW-1:0]];
    assign ev_abc   = ev_valid ? abc_mem[rd_ptr[AW-1:0]] : 3'b000;
    assign ev_ts    = ev_valid ? ts_mem[rd_ptr[AW-1:0]] : '0;

    // ---- drop accounting ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt <= 8'd0;
            ovf      <= 1'b0;
        end else if (drop) begin
            ovf <= 1'b1;
            if (drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_q_edge_logger.sv
// Directed bench for q_edge_logger (TS_W=4, DEPTH=4, FILTER_LEN=3).
// Stimulus changes and output sampling both happen on the falling clock edge.
// "now" counts rising edges completed since reset release; a q change made
// while now==k is sampled at edge k and its event carries timestamp
// k+LAT-1 (mod 16), becoming visible after edge k+LAT.
module tb_q_edge_logger;

    localparam int TS_W       = 4;
    localparam int DEPTH      = 4;
    localparam int FILTER_LEN = 3;
`ifdef Q_EDGE_LOGGER_GLITCH_FILTER_EN
    localparam int LAT  = FILTER_LEN;
    localparam int HOLD = FILTER_LEN + 1;
`else
    localparam int LAT  = 1;
    localparam int HOLD = 2;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [2:0]      abc = 3'b000;
    logic            q = 1'b0;
    logic            ev_ready = 1'b0;
    logic            ev_valid;
    logic            ev_rise;
    logic [2:0]      ev_abc;
    logic [TS_W-1:0] ev_ts;
    logic [7:0]      drop_cnt;
    logic            ovf;

    int total = 0;
    int bad   = 0;
    int now   = 0;

    q_edge_logger #(.TS_W(TS_W), .DEPTH(DEPTH), .FILTER_LEN(FILTER_LEN)) dut (
        .clk(clk), .rst(rst), .a(abc[2]), .b(abc[1]), .c(abc[0]), .q(q),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_rise(ev_rise),
        .ev_abc(ev_abc), .ev_ts(ev_ts), .drop_cnt(drop_cnt), .ovf(ovf)
    );

    always #5 clk = ~clk;

    function automatic logic [TS_W-1:0] tsx(input int v);
        return TS_W'(v);
    endfunction

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            now++;
        end
    endtask

    task automatic do_reset(input logic qv);
        rst = 1'b1;
        q = qv;
        ev_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        now = 0;
    endtask

    task automatic pop_one;
        ev_ready = 1'b1;
        cyc(1);
        ev_ready = 1'b0;
    endtask

    task automatic test_reset;
        abc = 3'b111;
        q = 1'b1;
        #1 rst = 1'b1;
        @(negedge clk);
        total++; if (ev_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", ev_valid); end
        total++; if (ev_rise !== 1'b0) begin bad++; $display("FAIL reset_rise: got %b want 0", ev_rise); end
        total++; if (ev_abc !== 3'b000) begin bad++; $display("FAIL reset_abc: got %b want 000", ev_abc); end
        total++; if (ev_ts !== 4'd0) begin bad++; $display("FAIL reset_ts: got %0d want 0", ev_ts); end
        total++; if (drop_cnt !== 8'd0) begin bad++; $display("FAIL reset_drop_cnt: got %0d want 0", drop_cnt); end
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    endtask

    task automatic test_single_rise;
        do_reset(1'b0);
        abc = 3'b101;
        cyc(10);
        q = 1'b1;
        cyc(LAT);
        total++; if (ev_valid !== 1'b0) begin bad++; $display("FAIL single_early_valid: got %b want 0", ev_valid); end
        cyc(1);
        total++; if (ev_valid !== 1'b1) begin bad++; $display("FAIL single_valid: got %b want 1", ev_valid); end
        total++; if (ev_rise !== 1'b1) begin bad++; $display("FAIL single_rise: got %b want 1", ev_rise); end
        total++; if (ev_abc !== 3'b101) begin bad++; $display("FAIL single_abc: got %b want 101", ev_abc); end
        total++; if (ev_ts !== tsx(10 + LAT - 1)) begin bad++; $display("FAIL single_ts: got %0d want %0d", ev_ts, tsx(10 + LAT - 1)); end
        pop_one();
        total++; if (ev_valid !== 1'b0) begin bad++; $display("FAIL single_drained: got %b want 0", ev_valid); end
    endtask

    task automatic test_overflow;
        do_reset(1'b0);
        abc = 3'b010;
        cyc(2);
        for (int i = 0; i < 6; i++) begin
            q = (i % 2 == 0);
            cyc(HOLD);
        end
        cyc(LAT + 1);
        total++; if (drop_cnt !== 8'd2) begin bad++; $display("FAIL ovf_drop_cnt: got %0d want 2", drop_cnt); end
        total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_flag: got %b want 1", ovf); end
        for (int i = 0; i < 4; i++) begin
            total++; if (ev_valid !== 1'b1) begin bad++; $display("FAIL ovf_valid[%0d]: got %b want 1", i, ev_valid); end
            total++; if (ev_rise !== (i % 2 == 0)) begin bad++; $display("FAIL ovf_rise[%0d]: got %b want %b", i, ev_rise, (i % 2 == 0)); end
            total++; if (ev_ts !== tsx(2 + i * HOLD + LAT - 1)) begin bad++; $display("FAIL ovf_ts[%0d]: got %0d want %0d", i, ev_ts, tsx(2 + i * HOLD + LAT - 1)); end
            pop_one();
        end
        total++; if (ev_valid !== 1'b0) begin bad++; $display("FAIL ovf_drained: got %b want 0", ev_valid); end
    endtask

    task automatic test_full_pop_write;
        int t5;
        logic [TS_W-1:0] exp_ts;
        do_reset(1'b0);
        abc = 3'b011;
        cyc(2);
        for (int i = 0; i < 4; i++) begin
            q = (i % 2 == 0);
            cyc(HOLD);
        end
        cyc(LAT + 1);
        t5 = now;
        q = 1'b1;
        cyc(LAT);
        ev_ready = 1'b1;
        cyc(1);
        ev_ready = 1'b0;
        total++; if (drop_cnt !== 8'd0) begin bad++; $display("FAIL fpw_drop_cnt: got %0d want 0", drop_cnt); end
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL fpw_ovf: got %b want 0", ovf); end
        for (int i = 1; i < 5; i++) begin
            exp_ts = (i == 4) ? tsx(t5 + LAT - 1) : tsx(2 + i * HOLD + LAT - 1);
            total++; if (ev_valid !== 1'b1) begin bad++; $display("FAIL fpw_valid[%0d]: got %b want 1", i, ev_valid); end
            total++; if (ev_rise !== (i % 2 == 0)) begin bad++; $display("FAIL fpw_rise[%0d]: got %b want %b", i, ev_rise, (i % 2 == 0)); end
            total++; if (ev_ts !== exp_ts) begin bad++; $display("FAIL fpw_ts[%0d]: got %0d want %0d", i, ev_ts, exp_ts); end
            pop_one();
        end
        total++; if (ev_valid !== 1'b0) begin bad++; $display("FAIL fpw_drained: got %b want 0", ev_valid); end
    endtask

    task automatic test_glitch;
        int t1;
        int t2;
        do_reset(1'b0);
        abc = 3'b100;
        cyc(2);
        t1 = now;
        q = 1'b1;
        cyc(2);
        q = 1'b0;
        cyc(LAT + 3);
`ifdef Q_EDGE_LOGGER_GLITCH_FILTER_EN
        total++; if (ev_valid !== 1'b0) begin bad++; $display("FAIL glitch_short_suppressed: got %b want 0", ev_valid); end
`else
        total++; if (ev_rise !== 1'b1 || ev_ts !== tsx(t1)) begin bad++; $display("FAIL glitch_short_rise: got rise=%b ts=%0d want rise=1 ts=%0d", ev_rise, ev_ts, tsx(t1)); end
        pop_one();
        total++; if (ev_valid !== 1'b1 || ev_rise !== 1'b0 || ev_ts !== tsx(t1 + 2)) begin bad++; $display("FAIL glitch_short_fall: got v=%b rise=%b ts=%0d want v=1 rise=0 ts=%0d", ev_valid, ev_rise, ev_ts, tsx(t1 + 2)); end
        pop_one();
        total++; if (ev_valid !== 1'b0) begin bad++; $display("FAIL glitch_short_drained: got %b want 0", ev_valid); end
`endif
        t2 = now;
        q = 1'b1;
        cyc(3);
        q = 1'b0;
        cyc(LAT + 2);
        total++; if (ev_valid !== 1'b1 || ev_rise !== 1'b1 || ev_ts !== tsx(t2 + LAT - 1)) begin bad++; $display("FAIL glitch_long_rise: got v=%b rise=%b ts=%0d want v=1 rise=1 ts=%0d", ev_valid, ev_rise, ev_ts, tsx(t2 + LAT - 1)); end
        pop_one();
        total++; if (ev_valid !== 1'b1 || ev_rise !== 1'b0 || ev_ts !== tsx(t2 + 3 + LAT - 1)) begin bad++; $display("FAIL glitch_long_fall: got v=%b rise=%b ts=%0d want v=1 rise=0 ts=%0d", ev_valid, ev_rise, ev_ts, tsx(t2 + 3 + LAT - 1)); end
        pop_one();
        total++; if (ev_valid !== 1'b0) begin bad++; $display("FAIL glitch_long_drained: got %b want 0", ev_valid); end
    endtask

    task automatic test_wrap_reset;
        do_reset(1'b0);
        abc = 3'b001;
        cyc(16 - LAT);
        q = 1'b1;
        cyc(LAT);
        q = 1'b0;
        cyc(LAT + 2);
        total++; if (ev_valid !== 1'b1 || ev_rise !== 1'b1 || ev_ts !== 4'd15) begin bad++; $display("FAIL wrap_first: got v=%b rise=%b ts=%0d want v=1 rise=1 ts=15", ev_valid, ev_rise, ev_ts); end
        pop_one();
        total++; if (ev_valid !== 1'b1 || ev_rise !== 1'b0 || ev_ts !== tsx(15 + LAT)) begin bad++; $display("FAIL wrap_second: got v=%b rise=%b ts=%0d want v=1 rise=0 ts=%0d", ev_valid, ev_rise, ev_ts, tsx(15 + LAT)); end
        pop_one();
        total++; if (ev_valid !== 1'b0) begin bad++; $display("FAIL wrap_drained: got %b want 0", ev_valid); end
        // overfill, pop two, then reset with two entries still queued
        for (int i = 0; i < 6; i++) begin
            q = (i % 2 == 0);
            cyc(HOLD);
        end
        cyc(LAT + 1);
        pop_one();
        pop_one();
        total++; if (ev_valid !== 1'b1 || drop_cnt !== 8'd2) begin bad++; $display("FAIL midrst_pre: got v=%b drop=%0d want v=1 drop=2", ev_valid, drop_cnt); end
        rst = 1'b1;
        #1;
        total++; if (ev_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid: got %b want 0", ev_valid); end
        total++; if (drop_cnt !== 8'd0) begin bad++; $display("FAIL midrst_drop_cnt: got %0d want 0", drop_cnt); end
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL midrst_ovf: got %b want 0", ovf); end
        @(negedge clk);
    endtask

    task automatic test_power_up;
        do_reset(1'b1);
        abc = 3'b110;
        cyc(LAT);
        total++; if (ev_valid !== 1'b0) begin bad++; $display("FAIL pwr_early_valid: got %b want 0", ev_valid); end
        cyc(1);
        total++; if (ev_valid !== 1'b1 || ev_rise !== 1'b1) begin bad++; $display("FAIL pwr_event: got v=%b rise=%b want v=1 rise=1", ev_valid, ev_rise); end
        total++; if (ev_ts !== tsx(LAT - 1)) begin bad++; $display("FAIL pwr_ts: got %0d want %0d", ev_ts, tsx(LAT - 1)); end
        total++; if (ev_abc !== 3'b110) begin bad++; $display("FAIL pwr_abc: got %b want 110", ev_abc); end
        pop_one();
        cyc(3);
        total++; if (ev_valid !== 1'b0) begin bad++; $display("FAIL pwr_single: got %b want 0", ev_valid); end
    endtask

    initial begin
        test_reset();
        test_single_rise();
        test_overflow();
        test_full_pop_write();
        test_glitch();
        test_wrap_reset();
        test_power_up();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
